// File: rtl/vga_dither_out.sv
// ============================================================================
// vga_dither_out
// ----------------------------------------------------------------------------
// Output stage between the test-pattern generator and the resistor-ladder
// VGA DAC. RGB565 pixels are expanded to 8 bits per channel by bit
// replication. A 4x4 ordered (Bayer) threshold is added, the result is
// saturated and reduced to OUT_BITS per channel, and blanking is forced.
// Syncs, enable and data all pass through the same two registers, so every
// output reflects the inputs sampled exactly two vga_clk edges earlier.
// frame_start pulses for one cycle when vga_vs first shows its active level.
//
// Optional feature macro: TEMPORAL_DITHER_EN
//   defined     -> frame_ph advances on each input vsync leading edge, so the
//                  Bayer index rotates from frame to frame.
//   not defined -> frame_ph stays 0 and the dither pattern is static.
//
// Parameters:
//   OUT_BITS        DAC bits per channel (4..8)
//   SYNC_ACTIVE_LOW 1 = syncs active-low (in and out), 0 = active-high
//
// Ports:
//   vga_clk                 pixel clock
//   rst                     synchronous reset, active-high
//   in_hs, in_vs, in_de     raw sync / enable from the generator
//   in_r, in_g, in_b        RGB565 pixel
//   dither_en               1 = dither, 0 = plain truncation
//   vga_hs, vga_vs, vga_de  re-timed sync / enable
//   vga_r, vga_g, vga_b     DAC data, OUT_BITS each
//   frame_start             one-cycle pulse on the output vsync leading edge
// ============================================================================
module vga_dither_out #(
    parameter int OUT_BITS        = 6,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                vga_clk,
    input  logic                rst,
    input  logic                in_hs,
    input  logic                in_vs,
    input  logic                in_de,
    input  logic [4:0]          in_r,
    input  logic [5:0]          in_g,
    input  logic [4:0]          in_b,
    input  logic                dither_en,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output logic [OUT_BITS-1:0] vga_r,
    output logic [OUT_BITS-1:0] vga_g,
    output logic [OUT_BITS-1:0] vga_b,
    output logic                frame_start
);

    // Number of bits dropped when going from 8 bits to the DAC width.
    localparam int   D        = 8 - OUT_BITS;
    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    if (OUT_BITS < 4 || OUT_BITS > 8) begin : g_bad_out_bits
        $error("vga_dither_out: OUT_BITS must be in 4..8");
    end

    // ------------------------------------------------------------------
    // Stage-1 registers (raw inputs expanded to 8 bits, dither index).
    // ------------------------------------------------------------------
    logic       r_hs1, r_vs1, r_de1, r_den1;
    logic [7:0] r_r8, r_g8, r_b8;
    logic [1:0] r_xi1, r_yi1;

    // Screen position of the pixel currently presented at the inputs.
    logic [10:0] r_x_pos;
    logic [9:0]  r_y_pos;
    logic [1:0]  r_frame_ph;

    logic       w_vs_lead;
    logic [3:0] w_bayer;
    logic [3:0] w_t;

    // r_vs1 is the previous input vsync, so this is the input leading edge.
    assign w_vs_lead = (in_vs == SYNC_ON) && (r_vs1 == SYNC_OFF);

    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] v;
        case ({y, x})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
            default: begin
                case (x)
                    2'd0:    v = 4'd15;
                    2'd1:    v = 4'd7;
                    2'd2:    v = 4'd13;
                    default: v = 4'd5;
                endcase
            end
        endcase
        return v;
    endfunction

    // Add threshold, clamp at 255 (white must never wrap to black), keep
    // the top OUT_BITS bits.
    function automatic logic [OUT_BITS-1:0] dither_ch(input logic [7:0] c8,
                                                      input logic [3:0] t);
        logic [8:0] s;
        logic [7:0] sat;
        s   = {1'b0, c8} + {5'b0, t};
        sat = s[8] ? 8'hFF : s[7:0];
        return sat[7 -: OUT_BITS];
    endfunction

    assign w_bayer = bayer(r_yi1, r_xi1);
    // Scale the 0..15 Bayer value to the size of one output LSB (D bits).
    assign w_t = (D == 0 || !r_den1) ? 4'd0 : 4'(w_bayer >> (4 - D));

    // ------------------------------------------------------------------
    // Stage 1 + position counters
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            // NOTE: sequential state is always written with non-blocking
            // assignments so every register samples pre-edge values.
            r_hs1      <= SYNC_OFF;
            r_vs1      <= SYNC_OFF;
            r_de1      <= 1'b0;
            r_den1     <= 1'b0;
            r_r8       <= 8'd0;
            r_g8       <= 8'd0;
            r_b8       <= 8'd0;
            r_xi1      <= 2'd0;
            r_yi1      <= 2'd0;
            r_x_pos    <= 11'd0;
            r_y_pos    <= 10'd0;
            r_frame_ph <= 2'd0;
        end else begin
            r_hs1  <= in_hs;
            r_vs1  <= in_vs;
            r_de1  <= in_de;
            r_den1 <= dither_en;
            r_r8   <= {in_r, in_r[4:2]};
            r_g8   <= {in_g, in_g[5:4]};
            r_b8   <= {in_b, in_b[4:2]};
            r_xi1  <= r_x_pos[1:0] ^ {2{r_frame_ph[0]}};
            r_yi1  <= r_y_pos[1:0] ^ {2{r_frame_ph[1]}};

            // r_x_pos holds the index the next active pixel will get: it is
            // cleared throughout blanking so the first de=1 pixel sees 0.
            if (in_de) begin
                if (r_x_pos != 11'h7FF) begin
                    r_x_pos <= r_x_pos + 11'd1;
                end
            end else begin
                r_x_pos <= 11'd0;
            end

            if (w_vs_lead) begin
                r_y_pos <= 10'd0;
            end else if (r_de1 && !in_de) begin
                r_y_pos <= r_y_pos + 10'd1;
            end

`ifdef TEMPORAL_DITHER_EN
            if (w_vs_lead) begin
                r_frame_ph <= r_frame_ph + 2'd1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: dither, reduce, blank, re-time
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            vga_hs      <= SYNC_OFF;
            vga_vs      <= SYNC_OFF;
            vga_de      <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hs <= r_hs1;
            vga_vs <= r_vs1;
            vga_de <= r_de1;
            if (r_de1) begin
                vga_r <= dither_ch(r_r8, w_t);
                vga_g <= dither_ch(r_g8, w_t);
                vga_b <= dither_ch(r_b8, w_t);
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
            // High in exactly the cycle vga_vs first turns active.
            frame_start <= (r_vs1 == SYNC_ON) && (vga_vs == SYNC_OFF);
        end
    end

endmodule
